// File: rtl/passcode_writer.sv
// -----------------------------------------------------------------------------
// passcode_writer
//
// Purpose
//   Controls changes to a four-digit BCD passcode. A change goes through four
//   steps: prog_req, the current code (verified), the new code, and the new
//   code again (confirmed). If the confirmation matches, the new code is
//   committed to code_out. Every step has an idle timeout. After MAX_FAIL
//   consecutive wrong old-code entries the block locks out for LOCK_S seconds.
//
// Ports
//   clk        in   1   system clock; all state changes on the rising edge
//   rst        in   1   asynchronous active-high reset
//   prog_req   in   1   one-cycle pulse that requests a code change
//   load_p     in   1   one-cycle pulse that samples digit_in
//   digit_in   in   4   switch digit; only meaningful while load_p=1
//   one_sec    in   1   one-cycle tick per second
//   code_out   out  16  stored code (four BCD nibbles)
//   busy       out  1   high in any state other than IDLE
//   locked     out  1   high in LOCKOUT
//   phase      out  3   current state encoding
//   digit_cnt  out  3   digits accepted in the current entry phase (0-4)
//   done_p     out  1   one-cycle pulse on a successful commit
//   err_p      out  1   one-cycle pulse on any abort
//   err_code   out  2   01 old mismatch, 10 confirm mismatch, 11 timeout
//
// State table
//   state       | meaning
//   IDLE        | waiting for prog_req; digit loads are ignored
//   VERIFY      | collecting the current code
//   NEW         | collecting the new code
//   CONFIRM     | collecting the new code a second time
//   CHECK_OLD   | one cycle: compare the entered code with code_out
//   CHECK_CONF  | one cycle: compare the confirmation with the staged code
//   LOCKOUT     | waiting LOCK_S seconds; only rst is honoured
// -----------------------------------------------------------------------------
module passcode_writer #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int          TIMEOUT_S    = 10,
  parameter int          LOCK_S       = 30,
  parameter int          MAX_FAIL     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_req,
  input  logic        load_p,
  input  logic [3:0]  digit_in,
  input  logic        one_sec,
  output logic [15:0] code_out,
  output logic        busy,
  output logic        locked,
  output logic [2:0]  phase,
  output logic [2:0]  digit_cnt,
  output logic        done_p,
  output logic        err_p,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_VERIFY     = 3'd1,
    S_NEW        = 3'd2,
    S_CONFIRM    = 3'd3,
    S_CHECK_OLD  = 3'd4,
    S_CHECK_CONF = 3'd5,
    S_LOCKOUT    = 3'd6
  } state_t;

  // The entry timeout and the lockout wait never run at the same time, so
  // they share one seconds counter that is sized for the longer of the two.
  localparam int SEC_MAX = (TIMEOUT_S > LOCK_S) ? TIMEOUT_S : LOCK_S;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

  localparam logic [SEC_W-1:0]  TIMEOUT_LAST = SEC_W'(TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0]  LOCK_LAST    = SEC_W'(LOCK_S - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAIL);

  localparam logic [1:0] ERR_OLD     = 2'b01;
  localparam logic [1:0] ERR_CONFIRM = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t              state_q, state_d;
  logic [15:0]         entry_q, entry_d;
  logic [15:0]         stage_q, stage_d;
  logic [15:0]         code_q, code_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                digit_ok;
  logic [15:0]         entry_shift;
  logic [FAIL_W-1:0]   fail_inc;

  // Only BCD digits count as keypresses; anything above 9 is as if no load
  // had happened at all, so it does not even restart the idle timer.
  assign digit_ok    = load_p && (digit_in <= 4'd9);
  assign entry_shift = {entry_q[11:0], digit_in};
  assign fail_inc    = fail_q + FAIL_W'(1);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    stage_d    = stage_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    sec_d      = sec_q;
    fail_d     = fail_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (prog_req) begin
          state_d    = S_VERIFY;
          entry_d    = 16'h0000;
          cnt_d      = 3'd0;
          sec_d      = '0;
          err_code_d = 2'b00;
        end
      end

      S_VERIFY, S_NEW, S_CONFIRM: begin
        if (digit_ok) begin
          // A keypress in the same cycle as a tick restarts the timer.
          sec_d = '0;
          if (cnt_q == 3'd3) begin
            unique case (state_q)
              S_VERIFY: begin
                entry_d = entry_shift;
                cnt_d   = 3'd4;
                state_d = S_CHECK_OLD;
              end
              S_NEW: begin
                stage_d = entry_shift;
                entry_d = 16'h0000;
                cnt_d   = 3'd0;
                state_d = S_CONFIRM;
              end
              default: begin
                entry_d = entry_shift;
                cnt_d   = 3'd4;
                state_d = S_CHECK_CONF;
              end
            endcase
          end else begin
            entry_d = entry_shift;
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (one_sec) begin
          if (sec_q == TIMEOUT_LAST) begin
            state_d    = S_IDLE;
            entry_d    = 16'h0000;
            cnt_d      = 3'd0;
            sec_d      = '0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end

      S_CHECK_OLD: begin
        entry_d = 16'h0000;
        cnt_d   = 3'd0;
        sec_d   = '0;
        if (entry_q == code_q) begin
          fail_d  = '0;
          state_d = S_NEW;
        end else begin
          fail_d     = fail_inc;
          err_d      = 1'b1;
          err_code_d = ERR_OLD;
          state_d    = (fail_inc == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
        end
      end

      S_CHECK_CONF: begin
        entry_d = 16'h0000;
        cnt_d   = 3'd0;
        sec_d   = '0;
        state_d = S_IDLE;
        if (entry_q == stage_q) begin
          code_d = stage_q;
          done_d = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_CONFIRM;
        end
      end

      S_LOCKOUT: begin
        if (one_sec) begin
          if (sec_q == LOCK_LAST) begin
            state_d = S_IDLE;
            sec_d   = '0;
            fail_d  = '0;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        entry_d = 16'h0000;
        cnt_d   = 3'd0;
        sec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      entry_q    <= 16'h0000;
      stage_q    <= 16'h0000;
      code_q     <= DEFAULT_CODE;
      cnt_q      <= 3'd0;
      sec_q      <= '0;
      fail_q     <= '0;
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      stage_q    <= stage_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      fail_q     <= fail_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign code_out  = code_q;
  assign busy      = (state_q != S_IDLE);
  assign locked    = (state_q == S_LOCKOUT);
  assign phase     = state_q;
  assign digit_cnt = cnt_q;
  assign done_p    = done_q;
  assign err_p     = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_passcode_writer.sv
// -----------------------------------------------------------------------------
// tb_passcode_writer
//
// Drives passcode_writer with directed and randomized change requests. The
// reference model tracks only the stored code and the count of consecutive
// wrong old-code entries, and predicts the outcome of each complete request.
// -----------------------------------------------------------------------------
module tb_passcode_writer;

  localparam int MAX_FAIL = 3;
  localparam int LOCK_S   = 30;
  localparam int TIMEOUT_S = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_req = 1'b0;
  logic        load_p = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        one_sec = 1'b0;
  logic [15:0] code_out;
  logic        busy;
  logic        locked;
  logic [2:0]  phase;
  logic [2:0]  digit_cnt;
  logic        done_p;
  logic        err_p;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [15:0] model_code = 16'h1234;
  int          model_fail = 0;

  passcode_writer #(
    .DEFAULT_CODE(16'h1234),
    .TIMEOUT_S   (TIMEOUT_S),
    .LOCK_S      (LOCK_S),
    .MAX_FAIL    (MAX_FAIL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .prog_req (prog_req),
    .load_p   (load_p),
    .digit_in (digit_in),
    .one_sec  (one_sec),
    .code_out (code_out),
    .busy     (busy),
    .locked   (locked),
    .phase    (phase),
    .digit_cnt(digit_cnt),
    .done_p   (done_p),
    .err_p    (err_p),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are set just after an edge and are sampled by the next edge.
  task automatic drive(input logic p, input logic l, input logic s, input logic [3:0] d);
    prog_req = p;
    load_p   = l;
    one_sec  = s;
    digit_in = d;
    cyc();
    prog_req = 1'b0;
    load_p   = 1'b0;
    one_sec  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    model_code = 16'h1234;
    model_fail = 0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) r = {r[11:0], 4'($urandom_range(0, 9))};
    return r;
  endfunction

  // Enter four digits; with noise, sprinkle invalid loads and a few ticks
  // (always well short of the timeout) between the real digits.
  task automatic enter_digits(input logic [15:0] val, input bit noise);
    logic [3:0] d;
    int k;
    for (int i = 0; i < 4; i++) begin
      d = val[(15 - 4 * i) -: 4];
      if (noise) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'b1, 1'b0, 4'($urandom_range(10, 15)));
          check("invalid_digit_cnt", 32'(digit_cnt), 32'(i));
        end
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) drive(1'b0, 1'b0, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), d);
      end else begin
        drive(1'b0, 1'b1, 1'b0, d);
      end
      if (i < 3) check("digit_cnt", 32'(digit_cnt), 32'(i + 1));
    end
  endtask

  task automatic attempt(input logic [15:0] old_c, input logic [15:0] new_c,
                         input logic [15:0] conf_c, input bit noise);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("prog_phase", 32'(phase), 32'd1);
    check("prog_busy", 32'(busy), 32'd1);
    check("prog_cnt", 32'(digit_cnt), 32'd0);
    check("prog_errcode", 32'(err_code), 32'd0);

    enter_digits(old_c, noise);
    check("phase_check_old", 32'(phase), 32'd4);
    cyc();
    if (old_c != model_code) begin
      model_fail++;
      check("old_err_p", 32'(err_p), 32'd1);
      check("old_err_code", 32'(err_code), 32'd1);
      check("old_code_kept", 32'(code_out), 32'(model_code));
      if (model_fail >= MAX_FAIL) begin
        check("lock_phase", 32'(phase), 32'd6);
        check("lock_locked", 32'(locked), 32'd1);
      end else begin
        check("old_fail_phase", 32'(phase), 32'd0);
        check("old_fail_busy", 32'(busy), 32'd0);
      end
      cyc();
      check("old_err_pulse_len", 32'(err_p), 32'd0);
      return;
    end
    model_fail = 0;
    check("verify_ok_phase", 32'(phase), 32'd2);
    check("verify_ok_err_p", 32'(err_p), 32'd0);

    enter_digits(new_c, noise);
    check("new_to_confirm_phase", 32'(phase), 32'd3);
    check("new_to_confirm_cnt", 32'(digit_cnt), 32'd0);

    enter_digits(conf_c, noise);
    check("phase_check_conf", 32'(phase), 32'd5);
    check("done_not_early", 32'(done_p), 32'd0);
    cyc();
    if (conf_c == new_c) begin
      model_code = new_c;
      check("commit_done_p", 32'(done_p), 32'd1);
      check("commit_err_p", 32'(err_p), 32'd0);
      check("commit_code", 32'(code_out), 32'(model_code));
      check("commit_busy", 32'(busy), 32'd0);
    end else begin
      check("conf_err_p", 32'(err_p), 32'd1);
      check("conf_done_p", 32'(done_p), 32'd0);
      check("conf_err_code", 32'(err_code), 32'd2);
      check("conf_code_kept", 32'(code_out), 32'(model_code));
      check("conf_phase", 32'(phase), 32'd0);
    end
    cyc();
    check("pulse_len_done", 32'(done_p), 32'd0);
    check("pulse_len_err", 32'(err_p), 32'd0);
  endtask

  task automatic do_lockout();
    for (int i = 0; i < LOCK_S; i++) begin
      if (i == 10) begin
        drive(1'b1, 1'b1, 1'b0, 4'd1);
        check("lock_ignores_prog", 32'(phase), 32'd6);
        check("lock_ignores_load", 32'(digit_cnt), 32'd0);
      end
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      if (i < LOCK_S - 1) check("lock_hold", 32'(locked), 32'd1);
      else begin
        check("lock_release", 32'(locked), 32'd0);
        check("lock_release_phase", 32'(phase), 32'd0);
      end
    end
    model_fail = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] o, n, c;

    apply_reset();
    check("rst_code", 32'(code_out), 32'h1234);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_cnt", 32'(digit_cnt), 32'd0);
    check("rst_done", 32'(done_p), 32'd0);
    check("rst_err", 32'(err_p), 32'd0);
    check("rst_errcode", 32'(err_code), 32'd0);

    // digit loads while idle do nothing
    drive(1'b0, 1'b1, 1'b0, 4'd5);
    check("idle_load_cnt", 32'(digit_cnt), 32'd0);
    check("idle_load_phase", 32'(phase), 32'd0);

    // confirm mismatch leaves the default code in place
    attempt(16'h1234, 16'h4321, 16'h4320, 1'b0);
    check("conf_mismatch_code", 32'(code_out), 32'h1234);

    // straight commit of 5678
    attempt(16'h1234, 16'h5678, 16'h5678, 1'b0);
    check("commit_5678", 32'(code_out), 32'h5678);

    // reset in the middle of CONFIRM
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter_digits(16'h5678, 1'b0);
    cyc();
    enter_digits(16'h1111, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    check("pre_rst_phase", 32'(phase), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_phase", 32'(phase), 32'd0);
    check("async_rst_code", 32'(code_out), 32'h1234);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_cnt", 32'(digit_cnt), 32'd0);
    check("async_rst_done", 32'(done_p), 32'd0);
    check("async_rst_err", 32'(err_p), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    model_code = 16'h1234;
    model_fail = 0;

    // three wrong old codes -> lockout
    for (int i = 0; i < MAX_FAIL; i++) attempt(16'h9999, 16'h0000, 16'h0000, 1'b0);
    do_lockout();

    // timeout: loads restart the timer, invalid loads do not
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("post_lock_prog", 32'(phase), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < TIMEOUT_S - 1; i++) drive(1'b0, 1'b0, 1'b1, 4'd0);
    check("no_timeout_9", 32'(phase), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd12);
    check("digit12_cnt", 32'(digit_cnt), 32'd2);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 4'd0);
    check("timeout_pending", 32'(phase), 32'd1);
    check("timeout_pending_err", 32'(err_p), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    check("timeout_err_p", 32'(err_p), 32'd1);
    check("timeout_err_code", 32'(err_code), 32'd3);
    check("timeout_phase", 32'(phase), 32'd0);
    check("timeout_code", 32'(code_out), 32'(model_code));
    cyc();
    check("timeout_pulse_len", 32'(err_p), 32'd0);
    check("errcode_held", 32'(err_code), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("prog_clears_errcode", 32'(err_code), 32'd0);
    for (int i = 0; i < TIMEOUT_S; i++) drive(1'b0, 1'b0, 1'b1, 4'd0);
    check("timeout2_phase", 32'(phase), 32'd0);

    // randomized requests
    for (int t = 0; t < 40; t++) begin
      o = ($urandom_range(0, 1) == 1) ? model_code : rand_bcd();
      n = rand_bcd();
      c = ($urandom_range(0, 9) < 7) ? n : rand_bcd();
      attempt(o, n, c, 1'b1);
      if (model_fail >= MAX_FAIL) do_lockout();
    end

    // reset during lockout clears the fail count
    while (model_fail < MAX_FAIL)
      attempt(model_code ^ 16'h0001, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 4'd0);
    check("lock_mid", 32'(locked), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_lock_locked", 32'(locked), 32'd0);
    check("rst_in_lock_phase", 32'(phase), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    model_code = 16'h1234;
    model_fail = 0;
    attempt(16'h1235, 16'h0000, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/passcode_writer.md
PASSCODE_WRITER -- requirements
Module: passcode_writer

Interface
REQ-001 The block SHALL take parameter DEFAULT_CODE, 16'h1234, the code held after reset (four BCD nibbles).
REQ-002 The block SHALL take parameter TIMEOUT_S, 10, the idle seconds allowed between digit entries before abort.
REQ-003 The block SHALL take parameter LOCK_S, 30, the lockout duration in seconds after MAX_FAIL failed verifications.
REQ-004 The block SHALL take parameter MAX_FAIL, 3, the number of consecutive old-code failures that triggers lockout.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- prog_req  in  1  single-cycle pulse (from ButtonShaper) requesting a code change.
- load_p  in  1  single-cycle pulse (from ButtonShaper) sampling digit_in.
- digit_in  in  4  switch digit, valid only when load_p=1.
- one_sec  in  1  single-cycle tick from OneSecTimer.
- code_out  out  16  stored code, read by the access checker.
- busy  out  1  high in any state other than IDLE.
- locked  out  1  high in LOCKOUT.
- phase  out  3  current FSM state encoding.
- digit_cnt  out  3  digits accepted in the current phase (0-4).
- done_p  out  1  one-cycle pulse on successful commit.
- err_p  out  1  one-cycle pulse on any abort.
- err_code  out  2  01 old mismatch, 10 confirm mismatch, 11 timeout; held until next err_p or prog_req.

Function
REQ-006 The FSM SHALL have states IDLE=0, VERIFY=1, NEW=2, CONFIRM=3, CHECK_OLD=4, CHECK_CONF=5, LOCKOUT=6.
REQ-007 In IDLE, prog_req SHALL move to VERIFY, clear digit_cnt, timer and err_code; load_p in IDLE SHALL be ignored.
REQ-008 Outside IDLE, prog_req SHALL be ignored.
REQ-009 In VERIFY/NEW/CONFIRM, load_p with digit_in<=9 SHALL shift the digit into a 16-bit entry register (first digit lands in [15:12]) and increment digit_cnt.
REQ-010 load_p with digit_in>9 SHALL be ignored: no shift, no count change, no timer reset.
REQ-011 The edge accepting the 4th digit SHALL move VERIFY->CHECK_OLD or CONFIRM->CHECK_CONF, and NEW->CONFIRM with digit_cnt cleared and the new code latched in a staging register.
REQ-012 CHECK_OLD SHALL last one cycle: on match with code_out, clear the fail counter and go to NEW; on mismatch, increment the fail counter, pulse err_p with err_code=01, and go to LOCKOUT if the count reaches MAX_FAIL, else IDLE.
REQ-013 CHECK_CONF SHALL last one cycle: on match, write code_out from staging, pulse done_p and go to IDLE; on mismatch, pulse err_p with err_code=10, go to IDLE and leave code_out unchanged.
REQ-014 done_p/err_p SHALL be high exactly the cycle after the CHECK state, i.e. two edges after the 4th load_p.
REQ-015 In VERIFY/NEW/CONFIRM, a seconds counter SHALL increment on one_sec and clear on an accepted load_p; if both occur in the same cycle, the load wins.
REQ-016 When the counter reaches TIMEOUT_S, the FSM SHALL go to IDLE and pulse err_p with err_code=11; code_out is unchanged and the fail counter is unchanged.
REQ-017 LOCKOUT SHALL count LOCK_S one_sec ticks, then go to IDLE with the fail counter cleared; all inputs except rst are ignored.
REQ-018 code_out SHALL change only in CHECK_CONF on match, or on reset.

Reset
REQ-019 rst SHALL asynchronously force IDLE, code_out=DEFAULT_CODE, with all other outputs, counters and the fail count set to 0, including mid-entry and during LOCKOUT.

Verification
REQ-020 Bench SHALL apply prog_req, digits 1,2,3,4, then 5,6,7,8 twice -> done_p one cycle two edges after the last load, code_out=16'h5678, busy=0.
REQ-021 Bench SHALL apply prog_req, then 9,9,9,9, three times -> err_p/err_code=01 each time; after the third, locked=1 for 30 one_sec ticks, then IDLE, and prog_req is accepted again.
REQ-022 Bench SHALL apply prog_req, 1234, new 4321, confirm 4320 -> err_code=10, code_out stays 16'h1234.
REQ-023 Bench SHALL apply prog_req, two digits, then 10 one_sec ticks with no load -> err_p, err_code=11, phase=0; digit_in=12 with load_p mid-entry -> digit_cnt unchanged.
REQ-024 Bench SHALL assert rst during CONFIRM after a prior commit of 16'h5678 -> immediately IDLE, code_out=16'h1234, all pulses 0.
